sha256_padder: RTL and testbench
================================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter BYTE_CNT_W, default 32, width of the message byte counter (maximum message length 2^BYTE_CNT_W-1 bytes).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_valid_i  input  1  message byte valid.
REQ-005 SHALL have port s_data_i  input  8  message byte.
REQ-006 SHALL have port s_last_i  input  1  marks the final byte of a message; qualified by s_valid_i.
REQ-007 SHALL have port s_ready_o  output  1  byte accepted when s_valid_i & s_ready_o.
REQ-008 SHALL have port dat_vaild_o  output  1  word valid to the hash core.
REQ-009 SHALL have port dat_lsb_o  output  32  chunk word; earliest message byte in bits [7:0].
REQ-010 SHALL have port hash_busy_i  input  1  hash core busy.
REQ-011 SHALL have port irq_finish_i  input  1  hash core chunk-complete pulse.
REQ-012 SHALL have port msg_done_o  output  1  one-cycle pulse when the last chunk of a message is hashed.

Function
REQ-013 SHALL use states FILL, PAD, SEND, WAIT, LEN, with FILL as the reset state.
REQ-014 FILL: s_ready_o=1; each accepted byte SHALL be written to a 64-byte chunk buffer at position p (0..63), p++, and the byte counter SHALL increment.
REQ-015 FILL: on acceptance with p becoming 64 and no s_last_i, the next state SHALL be SEND; otherwise it SHALL stay in FILL.
REQ-016 FILL: on accepting the s_last_i byte, the next state SHALL be PAD; if that byte filled position 63, SEND of the full chunk SHALL be done first, then PAD with p=0.
REQ-017 PAD: one cycle; byte p SHALL be 0x80, bytes p+1..63 SHALL be 0x00; if p<=55, bytes 56..63 SHALL hold the 64-bit big-endian bit length (byte_count<<3, zero-extended) and the chunk is marked final.
REQ-018 SEND: SHALL enter only when hash_busy_i=0; SHALL then drive dat_vaild_o=1 for exactly 16 consecutive cycles, word i = {byte4i+3, byte4i+2, byte4i+1, byte4i}, i=0..15 (byte4i in bits [7:0]).
REQ-019 WAIT: s_ready_o=0 and dat_vaild_o=0; on irq_finish_i=1, the next state SHALL be: LEN if padding is pending without length, otherwise FILL (p=0).
REQ-020 LEN: one cycle; bytes 0..55 SHALL be 0x00 and bytes 56..63 SHALL hold the length; the chunk is marked final, then SEND.
REQ-021 msg_done_o SHALL pulse on the cycle after irq_finish_i for a final chunk; the byte counter SHALL clear at the same time.
REQ-022 s_ready_o SHALL be 0 in PAD, SEND, WAIT and LEN; while s_ready_o=0, s_valid_i/s_data_i/s_last_i SHALL be ignored.
REQ-023 dat_lsb_o SHALL be 0 whenever dat_vaild_o=0.
REQ-024 A message SHALL contain at least 1 byte; the byte counter SHALL wrap modulo 2^BYTE_CNT_W.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state FILL, p=0, byte counter 0, buffer 0, s_ready_o=0 during reset and 1 from the first clock after release, dat_vaild_o=0, dat_lsb_o=0, msg_done_o=0.
REQ-026 Reset mid-SEND SHALL abort the chunk immediately, with no further words issued.

Configuration
REQ-027 With macro SHA256_PADDER_CHUNK_CNT_EN defined, the block SHALL add output chunk_cnt_o [15:0]; it resets to 0, increments on each irq_finish_i seen in WAIT, clears together with msg_done_o, and wraps at 0xFFFF.
REQ-028 Without SHA256_PADDER_CHUNK_CNT_EN, the port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-029 "abc" (61 62 63, last on 63) -> one SEND: word0=0x80636261, words1-14=0, word15=0x18000000; msg_done_o pulses once after irq_finish_i.
REQ-030 55 bytes 0x00 -> one chunk: word13=0x80000000, word15=0xB8010000.
REQ-031 56 bytes 0x00 -> chunk1: word14=0x00000080, word15=0; after irq_finish_i, LEN chunk: words0-14=0, word15=0xC0010000; two SENDs total.
REQ-032 64 bytes 0x00 -> full data chunk, then chunk with word0=0x00000080, word15=0x00020000.
REQ-033 hash_busy_i held high for 10 cycles while a chunk is ready -> no dat_vaild_o until hash_busy_i=0, then 16 consecutive words.
REQ-034 rst_n asserted at the 5th SEND word -> dat_vaild_o=0 the same cycle; after release, s_ready_o=1 and a fresh "abc" produces the REQ-029 output.

Source files
------------

// File: rtl/sha256_padder_if.sv
// Byte-stream ingress and hash-core word egress of the SHA-256 padder.
// The padder takes the slave modport; the environment drives master.
`timescale 1ns/1ps
interface sha256_padder_if;
  logic        s_valid_i;
  logic [7:0]  s_data_i;
  logic        s_last_i;
  logic        s_ready_o;
  logic        dat_vaild_o;
  logic [31:0] dat_lsb_o;
  logic        hash_busy_i;
  logic        irq_finish_i;
  logic        msg_done_o;

  modport master (
    output s_valid_i, s_data_i, s_last_i, hash_busy_i, irq_finish_i,
    input  s_ready_o, dat_vaild_o, dat_lsb_o, msg_done_o
  );
  modport slave (
    input  s_valid_i, s_data_i, s_last_i, hash_busy_i, irq_finish_i,
    output s_ready_o, dat_vaild_o, dat_lsb_o, msg_done_o
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs bytes into 64-byte chunks, appends 0x80 and the bit length.
// Optional SHA256_PADDER_CHUNK_CNT_EN adds chunk_cnt_o (chunks hashed in the current message).
`timescale 1ns/1ps
module sha256_padder #(
  parameter int BYTE_CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SHA256_PADDER_CHUNK_CNT_EN
  output logic [15:0] chunk_cnt_o,
`endif
  sha256_padder_if.slave bus
);

  typedef enum logic [2:0] {FILL, PAD, SEND, WAIT, LEN} state_t;

  state_t                  state;
  logic [63:0][7:0]        chunk;
  logic [5:0]              p;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic [4:0]              widx;
  logic                    sending;
  logic                    pad_pend;   // last byte closed a full chunk; 0x80 chunk still owed
  logic                    len_pend;   // 0x80 emitted but length did not fit
  logic                    final_chk;
  logic                    ready_q;
  logic                    vld_q;
  logic [31:0]             word_q;
  logic                    done_q;
  logic [63:0]             len_bits;
  logic                    acc;
`ifdef SHA256_PADDER_CHUNK_CNT_EN
  logic [15:0]             chunk_cnt;
  assign chunk_cnt_o = chunk_cnt;
`endif

  assign len_bits      = 64'(byte_cnt) << 3;
  assign acc           = bus.s_valid_i && ready_q;
  assign bus.s_ready_o   = ready_q;
  assign bus.dat_vaild_o = vld_q;
  assign bus.dat_lsb_o   = word_q;
  assign bus.msg_done_o  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      chunk     <= '0;
      p         <= '0;
      byte_cnt  <= '0;
      widx      <= '0;
      sending   <= 1'b0;
      pad_pend  <= 1'b0;
      len_pend  <= 1'b0;
      final_chk <= 1'b0;
      ready_q   <= 1'b0;
      vld_q     <= 1'b0;
      word_q    <= '0;
      done_q    <= 1'b0;
`ifdef SHA256_PADDER_CHUNK_CNT_EN
      chunk_cnt <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        FILL: begin
          ready_q <= 1'b1;
          if (acc) begin
            chunk[p] <= bus.s_data_i;
            p        <= p + 6'd1;
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            if (p == 6'd63) begin
              state    <= SEND;
              ready_q  <= 1'b0;
              pad_pend <= bus.s_last_i;
            end else if (bus.s_last_i) begin
              state   <= PAD;
              ready_q <= 1'b0;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < 64; i++) begin
            if (6'(i) == p)
              chunk[i] <= 8'h80;
            else if (6'(i) > p)
              chunk[i] <= (p <= 6'd55 && i >= 56) ? len_bits[8*(63-i) +: 8] : 8'h00;
          end
          final_chk <= (p <= 6'd55);
          len_pend  <= (p > 6'd55);
          pad_pend  <= 1'b0;
          state     <= SEND;
        end
        LEN: begin
          for (int i = 0; i < 64; i++)
            chunk[i] <= (i >= 56) ? len_bits[8*(63-i) +: 8] : 8'h00;
          final_chk <= 1'b1;
          len_pend  <= 1'b0;
          state     <= SEND;
        end
        SEND: begin
          // the burst only starts once the core is idle; then 16 back-to-back words
          if (!sending) begin
            if (!bus.hash_busy_i) begin
              sending <= 1'b1;
              vld_q   <= 1'b1;
              word_q  <= chunk[0 +: 4];
              widx    <= 5'd1;
            end
          end else if (widx == 5'd16) begin
            sending <= 1'b0;
            vld_q   <= 1'b0;
            word_q  <= '0;
            widx    <= '0;
            state   <= WAIT;
          end else begin
            word_q <= chunk[{widx[3:0], 2'b00} +: 4];
            widx   <= widx + 5'd1;
          end
        end
        WAIT: begin
          if (bus.irq_finish_i) begin
`ifdef SHA256_PADDER_CHUNK_CNT_EN
            chunk_cnt <= final_chk ? 16'd0 : chunk_cnt + 16'd1;
`endif
            if (final_chk) begin
              done_q    <= 1'b1;
              byte_cnt  <= '0;
              final_chk <= 1'b0;
            end
            if (len_pend)
              state <= LEN;
            else if (pad_pend)
              state <= PAD;
            else begin
              state   <= FILL;
              p       <= '0;
              ready_q <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: known vectors, busy/reset corner cases,
// and random messages checked against a plain SHA-256 padding model.
`timescale 1ns/1ps
module tb_sha256_padder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_padder_if bus ();
`ifdef SHA256_PADDER_CHUNK_CNT_EN
  logic [15:0] chunk_cnt;
  sha256_padder #(.BYTE_CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .chunk_cnt_o(chunk_cnt), .bus(bus));
`else
  sha256_padder #(.BYTE_CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wcnt = 0;
  int irq_at = 0;
  bit irq_pend = 0;
  int done_cnt = 0;
  int lsb_err = 0;
  logic [31:0] got_q[$];

  typedef struct {
    int          len;      // message length; 0 selects "abc"
    int          idx;
    logic [31:0] exp;
    int          nwords;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Standard SHA-256 padding, then little-endian packing of each 4-byte group.
  task automatic model(input logic [7:0] m[$], output logic [31:0] w[$]);
    logic [7:0]  q[$];
    logic [63:0] bl;
    q = m;
    bl = 64'(m.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int k = 7; k >= 0; k--) q.push_back(bl[8*k +: 8]);
    w = {};
    for (int k = 0; k < q.size() / 4; k++)
      w.push_back({q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]});
  endtask

  // Hash-core stand-in plus output monitor, all on the falling edge.
  initial begin
    bus.irq_finish_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        wcnt = 0; irq_pend = 0; bus.irq_finish_i = 1'b0;
      end else begin
        if (bus.irq_finish_i) bus.irq_finish_i = 1'b0;
        else if (irq_pend && cyc >= irq_at) begin
          bus.irq_finish_i = 1'b1; irq_pend = 0;
        end
        if (bus.dat_vaild_o) begin
          got_q.push_back(bus.dat_lsb_o);
          wcnt++;
          if (wcnt == 16) begin
            wcnt = 0; irq_pend = 1; irq_at = cyc + int'($urandom_range(1, 4));
          end
        end else if (bus.dat_lsb_o != 32'd0) lsb_err++;
        if (bus.msg_done_o) done_cnt++;
      end
    end
  end

  task automatic send_msg(input logic [7:0] m[$], input int gap);
    int t;
    @(negedge clk);
    for (int i = 0; i < m.size(); i++) begin
      repeat ($urandom_range(0, gap)) @(negedge clk);
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = m[i];
      bus.s_last_i  = (i == m.size() - 1);
      t = 0;
      while (!bus.s_ready_o && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) chk("ready_timeout", 64'(t), 64'd0);
      @(negedge clk);
      bus.s_valid_i = 1'b0;
      bus.s_last_i  = 1'b0;
      bus.s_data_i  = 8'($urandom);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 4000) begin @(negedge clk); t++; end
    chk("done_timeout", 64'(t < 4000), 64'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic run_msg(input logic [7:0] m[$], input int gap);
    got_q = {};
    done_cnt = 0;
    send_msg(m, gap);
    wait_done();
  endtask

  task automatic make_msg(input int len, output logic [7:0] m[$]);
    m = {};
    if (len == 0) m = {8'h61, 8'h62, 8'h63};
    else for (int i = 0; i < len; i++) m.push_back(8'h00);
  endtask

  task automatic cmp_model(input string name, input logic [7:0] m[$]);
    logic [31:0] w[$];
    model(m, w);
    chk({name, "_nwords"}, 64'(got_q.size()), 64'(w.size()));
    for (int k = 0; k < w.size() && k < got_q.size(); k++)
      if (got_q[k] !== w[k]) begin
        chk($sformatf("%s_w%0d", name, k), 64'(got_q[k]), 64'(w[k]));
        break;
      end
    chk({name, "_done"}, 64'(done_cnt), 64'd1);
  endtask

  vec_t vecs[$];
  logic [7:0] msg[$];

  initial begin
    int prev;
    int t;
    bus.s_valid_i = 1'b0; bus.s_data_i = 8'h00; bus.s_last_i = 1'b0; bus.hash_busy_i = 1'b0;

    vecs = '{
      '{0,  0, 32'h80636261, 16}, '{0, 1, 32'h0, 16}, '{0, 14, 32'h0, 16}, '{0, 15, 32'h18000000, 16},
      '{55, 13, 32'h80000000, 16}, '{55, 15, 32'hB8010000, 16},
      '{56, 14, 32'h00000080, 32}, '{56, 15, 32'h0, 32}, '{56, 16, 32'h0, 32}, '{56, 31, 32'hC0010000, 32},
      '{64, 0, 32'h0, 32}, '{64, 16, 32'h00000080, 32}, '{64, 31, 32'h00020000, 32}
    };

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.s_ready_o), 64'd0);
    chk("rst_vld", 64'(bus.dat_vaild_o), 64'd0);
    chk("rst_lsb", 64'(bus.dat_lsb_o), 64'd0);
    chk("rst_done", 64'(bus.msg_done_o), 64'd0);
`ifdef SHA256_PADDER_CHUNK_CNT_EN
    chk("rst_chunk_cnt", 64'(chunk_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(bus.s_ready_o), 64'd1);

    // table vectors; a message is replayed only when the record changes it
    prev = -1;
    foreach (vecs[i]) begin
      if (vecs[i].len != prev) begin
        make_msg(vecs[i].len, msg);
        run_msg(msg, 1);
        chk($sformatf("vec%0d_nwords", i), 64'(got_q.size()), 64'(vecs[i].nwords));
        chk($sformatf("vec%0d_done", i), 64'(done_cnt), 64'd1);
        prev = vecs[i].len;
      end
      if (vecs[i].idx < got_q.size())
        chk($sformatf("vec%0d_len%0d_w%0d", i, vecs[i].len, vecs[i].idx), 64'(got_q[vecs[i].idx]), 64'(vecs[i].exp));
      else
        chk($sformatf("vec%0d_missing", i), 64'(got_q.size()), 64'(vecs[i].idx + 1));
    end

    // core busy holds the burst off, then 16 back-to-back words
    got_q = {}; done_cnt = 0;
    bus.hash_busy_i = 1'b1;
    make_msg(0, msg);
    send_msg(msg, 0);
    t = 0;
    repeat (10) begin @(negedge clk); if (bus.dat_vaild_o) t++; end
    chk("busy_no_valid", 64'(t), 64'd0);
    bus.hash_busy_i = 1'b0;
    t = 0;
    while (!bus.dat_vaild_o && t < 20) begin @(negedge clk); t++; end
    chk("busy_start", 64'(bus.dat_vaild_o), 64'd1);
    t = 0;
    repeat (16) begin if (bus.dat_vaild_o) t++; @(negedge clk); end
    chk("busy_run16", 64'(t), 64'd16);
    chk("busy_end", 64'(bus.dat_vaild_o), 64'd0);
    wait_done();
    cmp_model("busy", msg);

    // reset during the fifth word of a burst
    got_q = {}; done_cnt = 0;
    send_msg(msg, 0);
    t = 0;
    while (got_q.size() < 5 && t < 100) begin @(negedge clk); #2; t++; end
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 64'(bus.dat_vaild_o), 64'd0);
    chk("midrst_lsb", 64'(bus.dat_lsb_o), 64'd0);
    chk("midrst_ready", 64'(bus.s_ready_o), 64'd0);
    chk("midrst_words", 64'(got_q.size()), 64'd5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_nowords", 64'(got_q.size()), 64'd5);
    chk("midrst_ready_after", 64'(bus.s_ready_o), 64'd1);
    run_msg(msg, 0);
    cmp_model("post_rst_abc", msg);

    // random messages against the padding model
    for (int r = 0; r < 10; r++) begin
      msg = {};
      for (int i = 0; i < int'($urandom_range(1, 150)); i++) msg.push_back(8'($urandom));
      run_msg(msg, 3);
      cmp_model($sformatf("rand%0d_len%0d", r, msg.size()), msg);
    end

    chk("lsb_zero_when_idle", 64'(lsb_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
